seq_divider: RTL and testbench

- Multi-cycle 32-bit integer divider for the execute stage, paired with the single-cycle Adder/ALU datapath.
- Uses restoring division, one quotient bit per clock. Each bit is a trial subtract, the inverse of the adder's accumulate.
- Supports signed and unsigned operands, a start/busy/done handshake, and divide-by-zero flagging.
- The hazard unit stalls on busy_o.

---
 rtl/seq_divider_pkg.sv | 16 +
 rtl/seq_divider_if.sv | 33 +++
 rtl/seq_divider_div_step.sv | 25 ++
 rtl/seq_divider.sv | 122 ++++++++++++
 tb/tb_seq_divider.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Imported by the interface, the step datapath and the top.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between the execute stage and the divider.
// The master issues requests; the slave returns results.
interface seq_divider_if #(
  parameter int WIDTH = seq_divider_pkg::DIV_WIDTH
);

  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             div_zero_o;

  modport master (
    output start_i, signed_i,
    output dividend_i, divisor_i,
    input  busy_o, done_o,
    input  quotient_o, remainder_o,
    input  div_zero_o
  );

  modport slave (
    input  start_i, signed_i,
    input  dividend_i, divisor_i,
    output busy_o, done_o,
    output quotient_o, remainder_o,
    output div_zero_o
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference if non-negative.
module seq_divider_div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             quo_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  assign shifted = {rem, quo_msb};
  // Extra top bit acts as the borrow/sign of the trial difference
  assign trial   = {1'b0, shifted} - {2'b00, divisor};
  assign q_bit   = ~trial[WIDTH+1];
  assign next_rem = q_bit ? trial[WIDTH-1:0]
                          : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned divider, one quotient bit per clock.
// Magnitudes are divided, signs are applied in FIX.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic          clk_i,
  input  logic          rst_i,
  seq_divider_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  state_t state_q, state_d;

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] remd_q;
  logic [CW-1:0]    cnt_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             dz_q;
  logic             dz_out_q;

  logic [WIDTH-1:0] step_rem;
  logic             step_bit;
  logic             dvd_neg;
  logic             dvs_neg;
  logic             dvs_zero;

  assign dvd_neg  = bus.signed_i & bus.dividend_i[WIDTH-1];
  assign dvs_neg  = bus.signed_i & bus.divisor_i[WIDTH-1];
  assign dvs_zero = (bus.divisor_i == '0);

  seq_divider_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (rem_q),
    .quo_msb  (quo_q[WIDTH-1]),
    .divisor  (dvs_q),
    .next_rem (step_rem),
    .q_bit    (step_bit)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Divide-by-zero also passes through FIX so its results are
  // written by the same path as a normal completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start_i)
              state_d = dvs_zero ? FIX : CALC;
      CALC: if (cnt_q == '0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      quot_q   <= '0;
      remd_q   <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      dz_out_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.start_i) begin
          if (dvs_zero) begin
            quo_q  <= WIDTH'(DIV_ZERO_QUOT);
            rem_q  <= bus.dividend_i;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b1;
          end else begin
            quo_q  <= dvd_neg ? -bus.dividend_i
                              : bus.dividend_i;
            dvs_q  <= dvs_neg ? -bus.divisor_i
                              : bus.divisor_i;
            rem_q  <= '0;
            cnt_q  <= CW'(WIDTH - 1);
            qneg_q <= dvd_neg ^ dvs_neg;
            rneg_q <= dvd_neg;
            dz_q   <= 1'b0;
          end
        end
        CALC: begin
          rem_q <= step_rem;
          quo_q <= {quo_q[WIDTH-2:0], step_bit};
          cnt_q <= cnt_q - 1'b1;
        end
        FIX: begin
          quot_q   <= qneg_q ? -quo_q : quo_q;
          remd_q   <= rneg_q ? -rem_q : rem_q;
          dz_out_q <= dz_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o      = (state_q == CALC) |
                           (state_q == FIX);
  assign bus.done_o      = (state_q == DONE);
  assign bus.quotient_o  = quot_q;
  assign bus.remainder_o = remd_q;
  assign bus.div_zero_o  = dz_out_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: arithmetic, latency,
// handshake and asynchronous reset behaviour.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   lat;
  int   bsy;
  int   pulses;

  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(32)) bus ();

  seq_divider dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic issue(input logic sg,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic hold);
    @(negedge clk);
    bus.start_i    = 1'b1;
    bus.signed_i   = sg;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    @(posedge clk);
    if (!hold) begin
      #1 bus.start_i = 1'b0;
    end
  endtask

  // Counts edges after the accepting edge until done_o is seen.
  task automatic wait_done(input int poke,
                           output int edges,
                           output int busy_n);
    edges  = 0;
    busy_n = 0;
    @(negedge clk);
    while (bus.done_o !== 1'b1 && edges < 100) begin
      if (bus.busy_o === 1'b1) busy_n++;
      if (edges == poke) begin
        bus.start_i    = 1'b1;
        bus.dividend_i = 32'd999;
        bus.divisor_i  = 32'd3;
      end else if (edges == poke + 1) begin
        bus.start_i = 1'b0;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic run_div(input string tag,
                         input logic sg,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] eq,
                         input logic [31:0] er,
                         input logic ez,
                         input int elat);
    int e;
    int bn;
    issue(sg, a, b, 1'b0);
    wait_done(1000, e, bn);
    chk({tag, ".lat"}, e, elat);
    chk({tag, ".busy"}, bn, elat);
    chk({tag, ".q"}, bus.quotient_o, eq);
    chk({tag, ".r"}, bus.remainder_o, er);
    chk({tag, ".dz"}, {31'd0, bus.div_zero_o}, {31'd0, ez});
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".pulse"}, {31'd0, bus.done_o}, 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.start_i    = 1'b0;
    bus.signed_i   = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy", {31'd0, bus.busy_o}, 32'd0);
    chk("rst.done", {31'd0, bus.done_o}, 32'd0);
    chk("rst.q", bus.quotient_o, 32'd0);
    chk("rst.r", bus.remainder_o, 32'd0);
    chk("rst.dz", {31'd0, bus.div_zero_o}, 32'd0);
    rst = 1'b0;

    run_div("u100_7", 0, 32'd100, 32'd7,
            32'd14, 32'd2, 0, 33);
    run_div("sm7_2", 1, 32'hFFFFFFF9, 32'd2,
            32'hFFFFFFFD, 32'hFFFFFFFF, 0, 33);
    run_div("s7_m2", 1, 32'd7, 32'hFFFFFFFE,
            32'hFFFFFFFD, 32'd1, 0, 33);
    run_div("dz_s", 1, 32'h12345678, 32'd0,
            32'hFFFFFFFF, 32'h12345678, 1, 1);
    run_div("dz_u", 0, 32'h12345678, 32'd0,
            32'hFFFFFFFF, 32'h12345678, 1, 1);
    run_div("after_dz", 0, 32'd100, 32'd7,
            32'd14, 32'd2, 0, 33);
    run_div("ovf_s", 1, 32'h80000000, 32'hFFFFFFFF,
            32'h80000000, 32'd0, 0, 33);
    run_div("ovf_u", 0, 32'h80000000, 32'hFFFFFFFF,
            32'd0, 32'h80000000, 0, 33);
    run_div("zero_dvd", 1, 32'd0, 32'd5,
            32'd0, 32'd0, 0, 33);
    run_div("big_dvs", 0, 32'hFFFFFFFF, 32'hFFFFFFFE,
            32'd1, 32'd1, 0, 33);

    // Second start at edge 10 with new operands is ignored
    issue(0, 32'd100, 32'd7, 1'b0);
    wait_done(9, lat, bsy);
    chk("poke.lat", lat, 33);
    chk("poke.q", bus.quotient_o, 32'd14);
    chk("poke.r", bus.remainder_o, 32'd2);

    // start held high: next request accepted 35 edges later
    issue(0, 32'd100, 32'd7, 1'b1);
    wait_done(1000, lat, bsy);
    chk("hold.lat1", lat, 33);
    @(posedge clk);
    @(negedge clk);
    chk("hold.idle", {31'd0, bus.busy_o}, 32'd0);
    @(posedge clk);
    wait_done(1000, lat, bsy);
    chk("hold.lat2", lat, 33);
    chk("hold.q", bus.quotient_o, 32'd14);
    bus.start_i = 1'b0;
    @(posedge clk);

    // Asynchronous reset in the middle of CALC
    issue(1, 32'hFFFFFF9C, 32'd7, 1'b0);
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst.busy", {31'd0, bus.busy_o}, 32'd0);
    chk("arst.done", {31'd0, bus.done_o}, 32'd0);
    chk("arst.q", bus.quotient_o, 32'd0);
    chk("arst.r", bus.remainder_o, 32'd0);
    chk("arst.dz", {31'd0, bus.div_zero_o}, 32'd0);
    #1 rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) pulses++;
    end
    chk("arst.nodone", pulses, 0);
    run_div("post_rst", 1, 32'hFFFFFF9C, 32'd7,
            32'hFFFFFFF2, 32'hFFFFFFFE, 0, 33);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
